reg_op_sequencer: RTL and testbench
===================================

Name: reg_op_sequencer

Overview:
Upstream control stage for the general-purpose register block (cl/ld/inc/dec/sr/sl controls). It accepts one command at a time over a valid/ready handshake: clear, load, increment, decrement, shift right or shift left, with a repeat count. It drives the register's one-hot control strobes for the required number of cycles, then reports completion with the resulting register value. It is used wherever the datapath needs multi-step register operations, such as shift-by-N or add-small-constant, without the main FSM sequencing individual cycles.

Parameters:
DATA_WIDTH, 16, width of the controlled register and of the data paths.
AMT_WIDTH, 5, width of the repeat/shift-amount field.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command (IDLE only).
cmd_op  in  3  operation: 0 NOP, 1 CLR, 2 LD, 3 INC, 4 DEC, 5 SHR, 6 SHL, 7 reserved.
cmd_amt  in  AMT_WIDTH  repeat count for INC/DEC/SHR/SHL; ignored otherwise.
cmd_data  in  DATA_WIDTH  load value for LD.
cmd_fill  in  1  serial fill bit for SHR (ir) / SHL (il).
reg_q  in  DATA_WIDTH  current register output.
reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl  out  1 each  register control strobes.
reg_in  out  DATA_WIDTH  register parallel input.
reg_ir, reg_il  out  1 each  register serial fill inputs.
busy  out  1  high in RUN or DONE.
done  out  1  one-cycle completion pulse.
res_data  out  DATA_WIDTH  reg_q while done=1, else 0.
err  out  1  one-cycle pulse with done when op=7.

Behaviour:
- Reset (async, rst_n=0): state IDLE, count 0, latched op/data/fill 0. All strobes, done, err and busy are 0; res_data 0; cmd_ready 1 once rst_n=1. Outputs drop immediately, not at the next edge.
- FSM: IDLE -> RUN -> DONE -> IDLE. Also IDLE -> DONE when K=0.
- Accept: cmd_valid & cmd_ready at edge T latches op, data, fill and the computed cycle count K. cmd_ready=0 in RUN/DONE. cmd_valid while busy is ignored, with no state change.
- Cycle count K:
  - CLR, LD: K=1.
  - INC, DEC: K=cmd_amt, no clamp; the register wraps (0xFFFF+1=0x0000).
  - SHR, SHL: K=min(cmd_amt, DATA_WIDTH).
  - NOP, reserved: K=0.
- RUN: lasts exactly K cycles, T+1..T+K. Exactly one strobe matching the op is high each cycle; all others are 0.
  - reg_in = latched data during the LD cycle, else 0.
  - reg_ir = latched fill during SHR, else 0.
  - reg_il = latched fill during SHL, else 0.
  - The count decrements each cycle; leave RUN when the count reaches 1.
- DONE: one cycle at T+K+1. done=1, res_data=reg_q (final value), err=1 if op=7. All strobes are 0. Next cycle is IDLE with cmd_ready=1.
- Throughput: one command per K+2 cycles. A back-to-back command can be accepted on the cycle after done.
- Strobes never overlap, so the register's priority encoding is never exercised.
- Reset asserted mid-RUN aborts immediately. The register may hold a partially-shifted value; no done is issued.

Decomposition:
- Shared package: op encoding constants (OP_NOP..OP_RSV), state encoding (S_IDLE, S_RUN, S_DONE), and the DATA_WIDTH default shared with the register.
- No sub-module is required. The count/clamp logic is a small always block.
- A wrapper test harness instantiates reg_op_sequencer plus the register, with reg_q looped back.

Test Plan (DATA_WIDTH=16, with the register attached):
1. LD cmd_data=0x1234, accepted at T -> reg_ld=1 and reg_in=0x1234 at T+1 only; done at T+2 with res_data=0x1234.
2. From 0x1234, INC amt=3 -> reg_inc high T+1..T+3; done at T+4 with res_data=0x1237. From 0x0000, DEC amt=1 -> res_data=0xFFFF.
3. From 0x00F0, SHR amt=4 fill=1 -> reg_sr and reg_ir high 4 cycles; done at T+5 with res_data=0xF00F.
4. From 0xABCD, SHL amt=20 fill=0 -> clamped to 16 strobe cycles; done at T+17 with res_data=0x0000.
5. INC amt=0 -> no strobes, done at T+1 with res_data unchanged. op=7 -> done and err both pulse at T+1.
6. Hold cmd_valid through a SHR amt=5 -> second command accepted only on the cycle after done. Pull rst_n low at T+3 of a SHL amt=8 -> strobes, busy and done drop immediately; cmd_ready=1 after release.

Source files
------------

// File: rtl/reg_op_sequencer_pkg.sv
// Shared definitions for the register-operation sequencer.
//   - Default data / amount widths (the data width matches the register block).
//   - Command opcodes driven on cmd_op.
//   - Sequencer state encoding (IDLE -> RUN -> DONE -> IDLE).
package reg_op_sequencer_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int AMT_WIDTH_DEF  = 5;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_CLR = 3'd1;
   localparam logic [2:0] OP_LD  = 3'd2;
   localparam logic [2:0] OP_INC = 3'd3;
   localparam logic [2:0] OP_DEC = 3'd4;
   localparam logic [2:0] OP_SHR = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_RSV = 3'd7;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/reg_op_sequencer.sv
// Register-operation sequencer.
// Accepts one command (CLR/LD/INC/DEC/SHR/SHL with a repeat count), drives the
// register's one-hot control strobes for K cycles, then reports the result.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   cmd_valid, cmd_ready       command handshake
//   cmd_op, cmd_amt,
//   cmd_data, cmd_fill         command fields
//   reg_q                      register output (looped back)
//   reg_cl..reg_sl             register control strobes (at most one high)
//   reg_in, reg_ir, reg_il     register parallel / serial fill inputs
//   busy, done, res_data, err  status and completion
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only in IDLE (and out of reset), so a
// command presented while busy is simply held off; the fields are sampled only
// on the transfer edge and may change freely at any other time.
module reg_op_sequencer
   import reg_op_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int AMT_WIDTH  = AMT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [AMT_WIDTH-1:0]  cmd_amt,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic                  cmd_fill,
   input  logic [DATA_WIDTH-1:0] reg_q,
   output logic                  reg_cl,
   output logic                  reg_ld,
   output logic                  reg_inc,
   output logic                  reg_dec,
   output logic                  reg_sr,
   output logic                  reg_sl,
   output logic [DATA_WIDTH-1:0] reg_in,
   output logic                  reg_ir,
   output logic                  reg_il,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic                  err
);

   // Shifting more than DATA_WIDTH times changes nothing further. If the amount
   // field cannot even reach DATA_WIDTH the clamp can never trigger.
   localparam logic [AMT_WIDTH-1:0] SHIFT_MAX =
      (DATA_WIDTH >= (2 ** AMT_WIDTH)) ? {AMT_WIDTH{1'b1}} : AMT_WIDTH'(DATA_WIDTH);
   localparam logic [AMT_WIDTH-1:0] ONE = AMT_WIDTH'(1);

   logic [1:0]            state;
   logic [AMT_WIDTH-1:0]  count;
   logic [2:0]            op_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  fill_q;
   logic [AMT_WIDTH-1:0]  k_next;
   logic                  accept;
   logic                  run;

   // Number of strobe cycles the incoming command needs.
   always_comb begin
      k_next = '0;
      case (cmd_op)
         OP_CLR, OP_LD:   k_next = ONE;
         OP_INC, OP_DEC:  k_next = cmd_amt;
         OP_SHR, OP_SHL:  k_next = (cmd_amt > SHIFT_MAX) ? SHIFT_MAX : cmd_amt;
         default:         k_next = '0;
      endcase
   end

   assign accept = cmd_valid && cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         count  <= '0;
         op_q   <= OP_NOP;
         data_q <= '0;
         fill_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q   <= cmd_op;
                  data_q <= cmd_data;
                  fill_q <= cmd_fill;
                  count  <= k_next;
                  // Zero-length commands skip straight to the completion cycle.
                  state  <= (k_next == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               count <= count - ONE;
               if (count == ONE) state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // All outputs decode from registered state, so an async reset clears them
   // without waiting for a clock edge.
   assign run       = (state == S_RUN);
   assign reg_cl    = run && (op_q == OP_CLR);
   assign reg_ld    = run && (op_q == OP_LD);
   assign reg_inc   = run && (op_q == OP_INC);
   assign reg_dec   = run && (op_q == OP_DEC);
   assign reg_sr    = run && (op_q == OP_SHR);
   assign reg_sl    = run && (op_q == OP_SHL);
   assign reg_in    = reg_ld ? data_q : '0;
   assign reg_ir    = reg_sr && fill_q;
   assign reg_il    = reg_sl && fill_q;

   assign cmd_ready = (state == S_IDLE) && rst_n;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign err       = done && (op_q == OP_RSV);
   assign res_data  = done ? reg_q : '0;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Bench for reg_op_sequencer with a behavioural register looped back on reg_q.
module tb_reg_op_sequencer;

   localparam int DW = 16;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          reg_rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_op = '0;
   logic [AW-1:0] cmd_amt = '0;
   logic [DW-1:0] cmd_data = '0;
   logic          cmd_fill = 1'b0;
   logic [DW-1:0] reg_q;
   logic          reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl;
   logic [DW-1:0] reg_in;
   logic          reg_ir, reg_il;
   logic          busy, done, err;
   logic [DW-1:0] res_data;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_val;   // register value predicted by the reference model

   always #5 clk = ~clk;

   reg_op_sequencer #(.DATA_WIDTH(DW), .AMT_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
      .reg_q(reg_q),
      .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
      .reg_sr(reg_sr), .reg_sl(reg_sl),
      .reg_in(reg_in), .reg_ir(reg_ir), .reg_il(reg_il),
      .busy(busy), .done(done), .res_data(res_data), .err(err)
   );

   // Harness register: priority-encoded controls, reset only at bench start.
   always_ff @(posedge clk or negedge reg_rst_n) begin
      if (!reg_rst_n)   reg_q <= '0;
      else if (reg_cl)  reg_q <= '0;
      else if (reg_ld)  reg_q <= reg_in;
      else if (reg_inc) reg_q <= reg_q + 1'b1;
      else if (reg_dec) reg_q <= reg_q - 1'b1;
      else if (reg_sr)  reg_q <= {reg_ir, reg_q[DW-1:1]};
      else if (reg_sl)  reg_q <= {reg_q[DW-2:0], reg_il};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Number of strobe cycles a command should take.
   function automatic int k_of(input logic [2:0] op, input logic [AW-1:0] amt);
      case (op)
         3'd1, 3'd2: return 1;
         3'd3, 3'd4: return int'(amt);
         3'd5, 3'd6: return (int'(amt) > DW) ? DW : int'(amt);
         default:    return 0;
      endcase
   endfunction

   // Final register value computed arithmetically from the command.
   function automatic logic [DW-1:0] model(input logic [2:0] op, input logic [AW-1:0] amt,
                                           input logic [DW-1:0] v, input logic [DW-1:0] data,
                                           input logic fill);
      int n;
      logic [DW-1:0] ones;
      ones = '1;
      n = k_of(op, amt);
      case (op)
         3'd1: return '0;
         3'd2: return data;
         3'd3: return v + DW'(amt);
         3'd4: return v - DW'(amt);
         3'd5: begin
            if (n >= DW) return fill ? ones : '0;
            return (v >> n) | (fill ? ~(ones >> n) : '0);
         end
         3'd6: begin
            if (n >= DW) return fill ? ones : '0;
            return (v << n) | (fill ? ~(ones << n) : '0);
         end
         default: return v;
      endcase
   endfunction

   // Issue one command and watch it through to completion.
   task automatic run_cmd(input string tag, input logic [2:0] op, input logic [AW-1:0] amt,
                          input logic [DW-1:0] data, input logic fill);
      int k, done_at, overlap, bad_in, bad_busy, own, others;
      int sc[6];
      logic [5:0] s;
      logic [DW-1:0] exp;
      k = k_of(op, amt);
      exp = model(op, amt, exp_val, data, fill);
      foreach (sc[i]) sc[i] = 0;
      done_at = 0; overlap = 0; bad_in = 0; bad_busy = 0;
      @(negedge clk);
      cmd_op = op; cmd_amt = amt; cmd_data = data; cmd_fill = fill; cmd_valid = 1'b1;
      check({tag, "_ready"}, cmd_ready, 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      for (int n = 1; n <= 40 && done_at == 0; n++) begin
         @(negedge clk);
         s = {reg_sl, reg_sr, reg_dec, reg_inc, reg_ld, reg_cl};
         if ($countones(s) > 1) overlap++;
         for (int i = 0; i < 6; i++) sc[i] += int'(s[i]);
         if (reg_in !== (reg_ld ? data : '0)) bad_in++;
         if (reg_ir !== (reg_sr & fill) || reg_il !== (reg_sl & fill)) bad_in++;
         if (done) begin
            done_at = n;
            check({tag, "_res"}, res_data, exp);
            check({tag, "_err"}, err, (op == 3'd7));
            if ($countones(s) != 0 || !busy) bad_busy++;
         end else if (!busy || cmd_ready || err || res_data !== '0) bad_busy++;
      end
      own = (op >= 3'd1 && op <= 3'd6) ? sc[op - 3'd1] : 0;
      others = sc[0] + sc[1] + sc[2] + sc[3] + sc[4] + sc[5] - own;
      check({tag, "_latency"}, done_at, k + 1);
      check({tag, "_strobes"}, own, (op >= 3'd1 && op <= 3'd6) ? k : 0);
      check({tag, "_other_strobes"}, others, 0);
      check({tag, "_overlap"}, overlap, 0);
      check({tag, "_data_fill"}, bad_in, 0);
      check({tag, "_status"}, bad_busy, 0);
      exp_val = exp;
   endtask

   initial begin
      int inc_cnt, done_at, busy_drop, late_done;
      logic [2:0] r_op;

      // Reset state
      #2;
      check("rst_strobes", {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl}, 0);
      check("rst_status", {busy, done, err}, 0);
      check("rst_res", res_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1; reg_rst_n = 1'b1;
      #1 check("rst_ready", cmd_ready, 1);
      exp_val = '0;

      // Directed functional cases
      run_cmd("ld1234", 3'd2, 5'd0, 16'h1234, 1'b0);
      run_cmd("inc3", 3'd3, 5'd3, 16'h0, 1'b0);
      check("inc3_val", exp_val, 16'h1237);
      run_cmd("ld0", 3'd2, 5'd0, 16'h0000, 1'b0);
      run_cmd("dec1_wrap", 3'd4, 5'd1, 16'h0, 1'b0);
      run_cmd("ld00f0", 3'd2, 5'd0, 16'h00F0, 1'b0);
      run_cmd("shr4", 3'd5, 5'd4, 16'h0, 1'b1);
      check("shr4_val", exp_val, 16'hF00F);
      run_cmd("ldabcd", 3'd2, 5'd0, 16'hABCD, 1'b0);
      run_cmd("shl20_clamp", 3'd6, 5'd20, 16'h0, 1'b0);
      run_cmd("inc0", 3'd3, 5'd0, 16'h0, 1'b0);
      run_cmd("rsv", 3'd7, 5'd9, 16'h0, 1'b0);
      run_cmd("nop", 3'd0, 5'd3, 16'h0, 1'b0);
      run_cmd("clr", 3'd1, 5'd3, 16'hFFFF, 1'b0);

      // cmd_valid held through a SHR 5: next command only after done
      @(negedge clk);
      cmd_op = 3'd5; cmd_amt = 5'd5; cmd_fill = 1'b1; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_op = 3'd3; cmd_amt = 5'd2; cmd_fill = 1'b0;
      done_at = 0; busy_drop = 0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (!busy || cmd_ready) busy_drop++;
         if (done && done_at == 0) begin
            done_at = n;
            check("hold_shr_res", res_data, 16'hF800);
         end
      end
      check("hold_shr_latency", done_at, 6);
      check("hold_busy", busy_drop, 0);
      @(negedge clk);
      check("hold_ready_after_done", cmd_ready, 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      inc_cnt = 0; done_at = 0;
      for (int n = 1; n <= 10 && done_at == 0; n++) begin
         @(negedge clk);
         inc_cnt += int'(reg_inc);
         if (done) begin
            done_at = n;
            check("hold_inc_res", res_data, 16'hF802);
         end
      end
      check("hold_inc_latency", done_at, 3);
      check("hold_inc_strobes", inc_cnt, 2);
      exp_val = 16'hF802;

      // Reset mid-RUN of SHL 8
      run_cmd("ld00ff", 3'd2, 5'd0, 16'h00FF, 1'b0);
      @(negedge clk);
      cmd_op = 3'd6; cmd_amt = 5'd8; cmd_fill = 1'b1; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_pre_busy", {busy, reg_sl}, 2'b11);
      rst_n = 1'b0;
      #1;
      check("abort_strobes", {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_il}, 0);
      check("abort_status", {busy, done, err}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 check("abort_ready", cmd_ready, 1);
      late_done = 0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         late_done += int'(done) + int'(busy);
      end
      check("abort_no_done", late_done, 0);
      exp_val = reg_q;   // partial shift is not modelled; resync with a load
      run_cmd("ld5a5a", 3'd2, 5'd0, 16'h5A5A, 1'b0);

      // Randomized commands against the reference model
      for (int i = 0; i < 30; i++) begin
         r_op = 3'($urandom_range(0, 7));
         run_cmd($sformatf("rnd%0d", i), r_op, AW'($urandom_range(0, 31)),
                 DW'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
